// File: rtl/btn_press_decode.sv
// ---------------------------------------------------------------------------
// btn_press_decode
//   Debounces and classifies push-button activity. It consumes a periodic
//   one-cycle timebase tick and the rising/falling edge pulses of the
//   synchronised button line. It produces the debounced held level plus
//   one-cycle short-press, long-press and optional auto-repeat events.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   tick          in   one-cycle timebase strobe
//   data_redge    in   one-cycle rising-edge pulse of the button line
//   data_fedge    in   one-cycle falling-edge pulse of the button line
//   held          out  debounced button level
//   press_short   out  pulse: debounced release after a hold < LONG_TICKS
//   press_long    out  pulse: hold counter reaches LONG_TICKS
//   press_repeat  out  pulse: auto-repeat after a long press (REPEAT_EN)
//
// Configuration
//   REPEAT_EN     define to enable auto-repeat; otherwise press_repeat = 0
//
// All outputs are registered. Event pulses appear in the cycle after the
// input that decides them.
// ---------------------------------------------------------------------------
module btn_press_decode #(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned LONG_TICKS     = 50,
    parameter int unsigned REPEAT_TICKS   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic data_redge,
    input  logic data_fedge,
    output logic held,
    output logic press_short,
    output logic press_long,
    output logic press_repeat
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

    // Reject parameter sets that break the debounce/long/repeat ordering.
    if (DEBOUNCE_TICKS < 1 || LONG_TICKS <= DEBOUNCE_TICKS || REPEAT_TICKS < 1) begin : g_param_check
        $error("btn_press_decode: illegal DEBOUNCE_TICKS/LONG_TICKS/REPEAT_TICKS");
    end

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PRESS_DEB   = 2'd1,
        S_HELD        = 2'd2,
        S_RELEASE_DEB = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEB_W-1:0]    r_deb_cnt;
    logic [DEB_W-1:0]    w_deb_cnt_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                r_held;
    logic                w_held_nxt;
    logic                r_short;
    logic                w_short_nxt;
    logic                r_long;
    logic                w_long_nxt;

`ifdef REPEAT_EN
    localparam int unsigned REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0]    r_rep_cnt;
    logic [REP_W-1:0]    w_rep_cnt_nxt;
    logic                r_repeat;
    logic                w_repeat_nxt;
`endif

    // Edge qualification: opposite edges together are meaningless and are
    // dropped; any edge in a cycle swallows a coincident tick.
    logic w_rise;
    logic w_fall;
    logic w_tick;

    assign w_rise = data_redge & ~data_fedge;
    assign w_fall = data_fedge & ~data_redge;
    assign w_tick = tick & ~(data_redge | data_fedge);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_held     <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
`ifdef REPEAT_EN
            r_rep_cnt  <= '0;
            r_repeat   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_deb_cnt  <= w_deb_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_held     <= w_held_nxt;
            r_short    <= w_short_nxt;
            r_long     <= w_long_nxt;
`ifdef REPEAT_EN
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_repeat   <= w_repeat_nxt;
`endif
        end
    end

    // Next-state, counter and event decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_deb_cnt_nxt  = r_deb_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_short_nxt    = 1'b0;
        w_long_nxt     = 1'b0;
`ifdef REPEAT_EN
        w_rep_cnt_nxt  = r_rep_cnt;
        w_repeat_nxt   = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                w_deb_cnt_nxt  = '0;
                w_hold_cnt_nxt = '0;
`ifdef REPEAT_EN
                w_rep_cnt_nxt  = '0;
`endif
                if (w_rise) begin
                    w_state_nxt = S_PRESS_DEB;
                end
            end

            S_PRESS_DEB: begin
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_deb_cnt_nxt = '0;
                end else if (w_tick) begin
                    if (r_deb_cnt == DEB_LAST) begin
                        w_state_nxt    = S_HELD;
                        w_deb_cnt_nxt  = '0;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
                    end
                end
            end

            S_HELD: begin
                if (w_fall) begin
                    w_state_nxt   = S_RELEASE_DEB;
                    w_deb_cnt_nxt = '0;
                end else if (w_tick) begin
                    if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                    // The long event fires only on the transition into saturation.
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_long_nxt = 1'b1;
`ifdef REPEAT_EN
                        w_rep_cnt_nxt = '0;
`endif
                    end
`ifdef REPEAT_EN
                    // Once saturated, every tick advances the repeat timer.
                    if (r_hold_cnt == HOLD_MAX) begin
                        if (r_rep_cnt == REP_LAST) begin
                            w_rep_cnt_nxt = '0;
                            w_repeat_nxt  = 1'b1;
                        end else begin
                            w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
                        end
                    end
`endif
                end
            end

            S_RELEASE_DEB: begin
                if (w_rise) begin
                    w_state_nxt = S_HELD;
                end else if (w_tick) begin
                    if (r_deb_cnt == DEB_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_deb_cnt_nxt = '0;
                        w_short_nxt   = (r_hold_cnt < HOLD_MAX);
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Debounced level is high from acceptance of a press until acceptance of its release.
        w_held_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_DEB);
    end

    assign held        = r_held;
    assign press_short = r_short;
    assign press_long  = r_long;
`ifdef REPEAT_EN
    assign press_repeat = r_repeat;
`else
    assign press_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_decode.sv
// ---------------------------------------------------------------------------
// tb_btn_press_decode
//   Self-checking bench for btn_press_decode (DEBOUNCE_TICKS=4,
//   LONG_TICKS=50, REPEAT_TICKS=10). A behavioural model tracks the
//   debounced level, a pending-transition flag, a stable-tick count and an
//   unbounded hold tick count, and derives every expected output from them.
//   Directed press scenarios are followed by randomized tick/edge traffic.
// ---------------------------------------------------------------------------
module tb_btn_press_decode;

    localparam int DEB  = 4;
    localparam int LONG = 50;
    localparam int REP  = 10;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic tick       = 1'b0;
    logic data_redge = 1'b0;
    logic data_fedge = 1'b0;
    logic held;
    logic press_short;
    logic press_long;
    logic press_repeat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_press_decode #(
        .DEBOUNCE_TICKS (DEB),
        .LONG_TICKS     (LONG),
        .REPEAT_TICKS   (REP)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .data_redge   (data_redge),
        .data_fedge   (data_fedge),
        .held         (held),
        .press_short  (press_short),
        .press_long   (press_long),
        .press_repeat (press_repeat)
    );

    // Behavioural model: debounced level, pending transition, stable ticks,
    // and an unbounded count of ticks spent held.
    bit m_held;
    bit m_pend;
    int m_stable;
    int m_hold;
    bit e_short;
    bit e_long;
    bit e_rep;

    // Pulses observed from the DUT within one scenario.
    int n_short;
    int n_long;
    int n_rep;
    int n_held;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held   = 1'b0;
        m_pend   = 1'b0;
        m_stable = 0;
        m_hold   = 0;
        e_short  = 1'b0;
        e_long   = 1'b0;
        e_rep    = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit r, input bit f);
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (r && f) begin
            // contradictory edges: nothing happens
        end else if (r || f) begin
            if (!m_held && !m_pend && r) begin
                m_pend   = 1'b1;
                m_stable = 0;
            end else if (!m_held && m_pend && f) begin
                m_pend = 1'b0;
            end else if (m_held && !m_pend && f) begin
                m_pend   = 1'b1;
                m_stable = 0;
            end else if (m_held && m_pend && r) begin
                m_pend = 1'b0;
            end
        end else if (t) begin
            if (m_pend) begin
                m_stable++;
                if (m_stable == DEB) begin
                    m_pend = 1'b0;
                    if (!m_held) begin
                        m_held = 1'b1;
                        m_hold = 0;
                    end else begin
                        m_held  = 1'b0;
                        e_short = (m_hold < LONG);
                        m_hold  = 0;
                    end
                end
            end else if (m_held) begin
                m_hold++;
                e_long = (m_hold == LONG);
`ifdef REPEAT_EN
                e_rep = (m_hold > LONG) && (((m_hold - LONG) % REP) == 0);
`endif
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare all outputs.
    task automatic cyc(input bit t, input bit r, input bit f);
        tick       = t;
        data_redge = r;
        data_fedge = f;
        @(posedge clk);
        model_step(t, r, f);
        #1;
        check("held", held, m_held);
        check("press_short", press_short, e_short);
        check("press_long", press_long, e_long);
        check("press_repeat", press_repeat, e_rep);
        n_short += int'(press_short);
        n_long  += int'(press_long);
        n_rep   += int'(press_repeat);
        n_held  += int'(held);
        tick       = 1'b0;
        data_redge = 1'b0;
        data_fedge = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clr_counts();
        n_short = 0;
        n_long  = 0;
        n_rep   = 0;
        n_held  = 0;
    endtask

    initial begin
        model_reset();
        clr_counts();

        // Reset held for 3 clocks while the inputs toggle.
        for (int i = 0; i < 3; i++) begin
            tick       = 1'($urandom_range(0, 1));
            data_redge = 1'($urandom_range(0, 1));
            data_fedge = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_held", held, 0);
            check("rst_short", press_short, 0);
            check("rst_long", press_long, 0);
            check("rst_repeat", press_repeat, 0);
        end
        tick       = 1'b0;
        data_redge = 1'b0;
        data_fedge = 1'b0;
        rst_n      = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Clean short press.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(3);
        check("s2_held_before_4th", held, 0);
        ticks(1);
        check("s2_held_after_4th", held, 1);
        ticks(10);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(4);
        check("s2_short_count", n_short, 1);
        check("s2_long_count", n_long, 0);
        check("s2_held_end", held, 0);

        // Press bounce rejected.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(2);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(6);
        check("s3_held_seen", n_held, 0);
        check("s3_events", n_short + n_long + n_rep, 0);

        // Long press held 60 ticks.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        ticks(60);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(4);
        check("s4_long_count", n_long, 1);
        check("s4_short_count", n_short, 0);

        // Release bounce at hold 20, then a clean short release.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        ticks(20);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(2);
        cyc(1'b0, 1'b1, 1'b0);
        check("s5_held_after_bounce", held, 1);
        ticks(5);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(4);
        check("s5_short_count", n_short, 1);
        check("s5_long_count", n_long, 0);

        // Release bounce at hold 20; 30 more ticks must complete a long press.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        ticks(20);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(2);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(29);
        check("s5b_long_before", n_long, 0);
        ticks(1);
        check("s5b_long_after", n_long, 1);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(4);
        check("s5b_short_count", n_short, 0);

        // Press held 80 ticks: repeats only when the feature is built in.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        ticks(80);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(4);
        check("s6_long_count", n_long, 1);
`ifdef REPEAT_EN
        check("s6_repeat_count", n_rep, 3);
`else
        check("s6_repeat_count", n_rep, 0);
`endif

        // Edge with coincident tick: tick discarded, so 4 more ticks still needed.
        clr_counts();
        cyc(1'b1, 1'b1, 1'b0);
        ticks(3);
        check("sim_held_3", held, 0);
        cyc(1'b0, 1'b1, 1'b1);
        ticks(1);
        check("sim_held_4", held, 1);
        cyc(1'b1, 1'b0, 1'b1);
        ticks(4);
        check("sim_short", n_short, 1);

        // Reset asserted mid-press.
        clr_counts();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        ticks(10);
        rst_n = 1'b0;
        #2;
        check("midrst_held", held, 0);
        check("midrst_short", press_short, 0);
        check("midrst_long", press_long, 0);
        check("midrst_repeat", press_repeat, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Randomized traffic; alternate busy and quiet blocks so long holds occur.
        for (int blk = 0; blk < 12; blk++) begin
            int rate;
            rate = (blk % 2 == 1) ? 1 : 8;
            for (int i = 0; i < 1000; i++) begin
                int x;
                bit t;
                bit r;
                bit f;
                x = int'($urandom_range(0, 999));
                t = ($urandom_range(0, 1) == 0);
                r = (x < rate) || (x == 999 && blk == 4);
                f = (x >= rate && x < 2 * rate) || (x == 999 && blk == 4);
                cyc(t, r, f);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
